// File: rtl/aoi_sweep_ctrl.sv
// Exhaustive clocked sweep controller for a 4-input AOI cell (o = ~((a1&a2)|(b1&b2))).
// Optional macro STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module aoi_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned ERR_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_o,
    output logic [3:0]       vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_fail
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       ff_q, ff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             exp_c;
    logic             mismatch_c;

    assign exp_c      = ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
    assign mismatch_c = (dut_o != exp_c);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; abort outranks the CHECK result
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort)                    state_d = IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = CHECK;
            end
            CHECK: begin
                if (abort)                 state_d = IDLE;
`ifdef STOP_ON_FAIL_EN
                else if (mismatch_c)       state_d = DONE;
`endif
                else if (vec_q == 4'hF)    state_d = DONE;
                else                       state_d = SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        ff_d   = ff_q;
        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d = '0;
                    cnt_d = '0;
                    err_d = '0;
                    ff_d  = '0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    vec_d = '0;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (abort) begin
                    vec_d = '0;
                    cnt_d = '0;
                end else begin
                    if (mismatch_c) begin
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                        if (err_q == '0) ff_d  = vec_q;
                    end
                    if (state_d == SETTLE) begin
                        vec_d = vec_q + 4'd1;
                        cnt_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign pass       = done_q && (err_q == '0);

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Scoreboard bench for aoi_sweep_ctrl; honours STOP_ON_FAIL_EN in its reference model.
module tb_aoi_sweep_ctrl;

    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned ERR_W      = 5;
    localparam int MODE_STUCK0 = 0;
    localparam int MODE_STUCK1 = 1;
    localparam int MODE_GOOD   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             dut_o;
    logic [3:0]       vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       first_fail;

    int total = 0;
    int bad   = 0;
    int mode  = MODE_GOOD;

    typedef struct {
        logic [ERR_W-1:0] err;
        logic [3:0]       ff;
        logic             pass;
        logic [3:0]       vec;
        int               busy_cyc;
    } exp_t;

    exp_t sb_q[$];

    aoi_sweep_ctrl #(.SETTLE_CYC(SETTLE_CYC), .ERR_W(ERR_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .dut_o      (dut_o),
        .vec        (vec),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    // Model of the cell under control, optionally with a stuck-at fault
    always_comb begin
        if (mode == MODE_STUCK0)      dut_o = 1'b0;
        else if (mode == MODE_STUCK1) dut_o = 1'b1;
        else                          dut_o = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int m);
        exp_t       e;
        logic [3:0] vv;
        logic       good;
        logic       obs;
        int         nvec;
        e.err = '0;
        e.ff  = '0;
        e.vec = 4'hF;
        nvec  = 16;
        for (int v = 0; v < 16; v++) begin
            vv   = 4'(v);
            good = ~((vv[3] & vv[2]) | (vv[1] & vv[0]));
            obs  = (m == MODE_STUCK0) ? 1'b0 : (m == MODE_STUCK1) ? 1'b1 : good;
            if (obs != good) begin
                if (e.err == '0) e.ff = vv;
                e.err = e.err + ERR_W'(1);
`ifdef STOP_ON_FAIL_EN
                e.vec = vv;
                nvec  = v + 1;
                break;
`endif
            end
        end
        e.busy_cyc = nvec * int'(SETTLE_CYC + 1);
        e.pass     = (e.err == '0);
        return e;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full sweep: push expectation, run to done, pop and compare
    task automatic run_sweep(input int m, input bit dup_start);
        exp_t e;
        int   bc;
        int   cyc;
        mode = m;
        sb_q.push_back(model(m));
        pulse_start();
        bc  = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            if (busy === 1'b1) bc++;
            start = dup_start && (cyc == 10 || cyc == 40);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("sweep_done", 32'(done), 32'(1));
        check("sweep_busy_low", 32'(busy), 32'(0));
        check("sweep_busy_cycles", 32'(bc), 32'(e.busy_cyc));
        check("sweep_err_cnt", 32'(err_cnt), 32'(e.err));
        check("sweep_pass", 32'(pass), 32'(e.pass));
        check("sweep_vec", 32'(vec), 32'(e.vec));
        if (e.err != '0) check("sweep_first_fail", 32'(first_fail), 32'(e.ff));
    endtask

    task automatic wait_vec(input logic [3:0] target);
        int cyc;
        cyc = 0;
        while (vec !== target && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wait_vec_reached", 32'(vec), 32'(target));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #23;
        check("rst_vec", 32'(vec), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_pass", 32'(pass), 32'(0));
        check("rst_err", 32'(err_cnt), 32'(0));
        check("rst_ff", 32'(first_fail), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good cell with repeated start during busy, then stuck-at faults
        run_sweep(MODE_GOOD, 1'b1);
        run_sweep(MODE_STUCK1, 1'b0);
        run_sweep(MODE_STUCK0, 1'b0);

        // Abort in SETTLE of vec 5; error state is retained
`ifdef STOP_ON_FAIL_EN
        mode = MODE_GOOD;
`else
        mode = MODE_STUCK1;
`endif
        pulse_start();
        wait_vec(4'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_vec", 32'(vec), 32'(0));
        check("abort_done", 32'(done), 32'(0));
`ifdef STOP_ON_FAIL_EN
        check("abort_err_kept", 32'(err_cnt), 32'(0));
`else
        check("abort_err_kept", 32'(err_cnt), 32'(1));
        check("abort_ff_kept", 32'(first_fail), 32'(3));
`endif
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(busy), 32'(0));
        run_sweep(MODE_GOOD, 1'b0);

        // Abort coinciding with the failing CHECK of vec 3 must not count it
        mode = MODE_STUCK1;
        pulse_start();
        wait_vec(4'd3);
        repeat (SETTLE_CYC - 1) @(posedge clk);
        #1;
        check("pre_check_busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_check_err", 32'(err_cnt), 32'(0));
        check("abort_check_busy", 32'(busy), 32'(0));
        check("abort_check_done", 32'(done), 32'(0));

        // Asynchronous reset between edges mid-sweep
        mode = MODE_STUCK1;
        pulse_start();
        repeat (27) @(posedge clk);
        #1;
        check("pre_rst_err", 32'(err_cnt), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vec", 32'(vec), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_err", 32'(err_cnt), 32'(0));
        check("arst_ff", 32'(first_fail), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_sweep(MODE_GOOD, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aoi_sweep_ctrl.md
Name: aoi_sweep_ctrl

Overview:
Self-checking exhaustive sweep controller for the 4-input AND-OR-INVERT cell, where o = ~((a1&a2)|(b1&b2)). On a start pulse it drives all 16 input vectors {a1,a2,b1,b2} = 0000..1111 into the cell in ascending order. It waits a programmable settle time per vector and compares the cell output against an internally computed expected value. It counts mismatches and latches the first failing vector, replacing open-loop timed stimulus with an on-chip, clocked BIST-style sequencer.

Parameters:
SETTLE_CYC, 4, cycles vector is held before output is sampled; legal 1..255
ERR_W, 5, width of mismatch counter; must be >=5 so 16 fails are representable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a sweep
abort  in  1  synchronous cancel of a running sweep
dut_o  in  1  output of the AOI cell under control
vec  out  4  drive to AOI cell, bit order {a1,a2,b1,b2} = vec[3:0]
busy  out  1  high while sweep in progress
done  out  1  level, high from sweep completion until next accepted start
pass  out  1  done && err_cnt==0
err_cnt  out  ERR_W  number of mismatching vectors, saturating
first_fail  out  4  first vector that mismatched; valid when err_cnt!=0

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low immediately forces state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, settle counter=0. This also applies mid-sweep.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: next cycle state=SETTLE, vec=0, err_cnt=0, first_fail=0, done=0, busy=1, settle counter=0.
- start while busy is ignored.
- SETTLE: counter increments each cycle. After SETTLE_CYC cycles in SETTLE (counter==SETTLE_CYC-1), go to CHECK.
- CHECK (one cycle): exp = ~((vec[3]&vec[2])|(vec[1]&vec[0])).
  - If dut_o != exp: err_cnt increments, saturating at all-ones. first_fail is loaded with vec only if err_cnt was 0.
  - If vec==4'hF: go to DONE, busy=0, done=1. vec holds 4'hF.
  - Otherwise: vec=vec+1, counter=0, go to SETTLE.
- Timing: each vector occupies SETTLE_CYC+1 cycles. busy is high for exactly 16*(SETTLE_CYC+1) cycles. done rises on the cycle after the last CHECK.
- abort=1 in SETTLE or CHECK: next cycle state=IDLE, vec=0, busy=0, done=0. err_cnt and first_fail retain their values.
- abort in IDLE/DONE: no effect.
- abort has priority over the CHECK result in the same cycle; that vector is not counted.
- start and abort high together in IDLE/DONE: start wins.
- vec changes only on clk edges and is glitch-free (registered).
- pass is combinational from registered done and err_cnt.

Optional Feature:
STOP_ON_FAIL_EN
- Defined: on the first mismatch in CHECK, go directly to DONE: busy=0, done=1, err_cnt=1, vec holds the failing vector, first_fail=vec.
- Undefined: the sweep always runs all 16 vectors regardless of mismatches.

Test Plan:
1. Correct AOI model, SETTLE_CYC=4, start pulse at cycle 0 -> busy high cycles 1..80, done=1 from cycle 81, err_cnt=0, pass=1, vec=4'hF.
2. dut_o stuck at 1 -> err_cnt=7 (vectors 0011,0111,1011,1100,1101,1110,1111), first_fail=4'b0011, pass=0.
3. dut_o stuck at 0 -> err_cnt=9, first_fail=4'b0000, pass=0.
4. abort during SETTLE of vec=5 -> next cycle IDLE, busy=0, vec=0, done=0. A new start then gives a full 80-cycle sweep with err_cnt reset to 0.
5. rst_n low mid-sweep between clock edges -> all outputs zero immediately, without waiting for clk. start repeated during busy -> no restart and no change in sweep length.
6. STOP_ON_FAIL_EN defined, dut_o stuck at 1 -> done after CHECK of vec=4'b0011, err_cnt=1, vec=4'b0011, first_fail=4'b0011, total busy = 4*(SETTLE_CYC+1) cycles.
